// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Purpose
//   Shares the single register-file write port among NUM_REQ writeback
//   sources (ALU result, load data, CSR/mul-div result, ...). Each source owns
//   a small FIFO. A round-robin arbiter drains one FIFO head per cycle into a
//   registered write port that drives the register file directly. Requests that
//   target x0 are accepted but never stored, so they cost neither a FIFO slot
//   nor a write-port cycle.
//
// Handshake (requester side)
//   A request i transfers on a rising clock edge where req_valid[i] and
//   req_ready[i] are both high. req_ready[i] is a function of FIFO state only
//   (not full, and not in reset); it never looks at req_valid or the current
//   grant. While req_valid[i] is high the payload (req_rd, req_data slice) must
//   stay stable. There is no backpressure on the write port: a popped entry is
//   always written on the following cycle.
//
// Parameters
//   NUM_REQ     number of writeback requesters (2..4)
//   FIFO_DEPTH  entries per requester FIFO (power of two, >= 2)
//   XLEN        write data width
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  per requester: request valid
//   req_ready  per requester: FIFO can accept (low while reset is asserted)
//   req_rd     per requester destination register, requester i at [5i+4:5i]
//   req_data   per requester write data, requester i at [XLEN*i +: XLEN]
//   regWrite   registered write enable to the register file
//   rd         registered destination register (holds when no write)
//   writeData  registered write data (holds when no write)
//   wb_idle    all FIFOs empty and no write in flight
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    regWrite,
  output logic [4:0]              rd,
  output logic [XLEN-1:0]         writeData,
  output logic                    wb_idle
);

  // Address bits into a FIFO, pointer bits (one extra wrap bit), grant index bits.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      full;
  logic [NUM_REQ-1:0]      empty;
  logic [NUM_REQ-1:0]      push;
  logic [NUM_REQ-1:0]      pop;
  logic [NUM_REQ*5-1:0]    head_rd_all;
  logic [NUM_REQ*XLEN-1:0] head_data_all;

  logic                    grant_valid;
  logic [GW-1:0]           grant_idx;
  logic [GW-1:0]           cand;
  logic [GW-1:0]           last_grant;
  logic [4:0]              sel_rd;
  logic [XLEN-1:0]         sel_data;

  // ---------------------------------------------------------------------------
  // Per-requester FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      mem_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] mem_data [FIFO_DEPTH];

    // Pointers carry one wrap bit: equal means empty, equal low bits with a
    // differing wrap bit means full.
    assign empty[i] = (wr_ptr == rd_ptr);
    assign full[i]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready is forced low while reset is held so nothing is accepted into a
    // FIFO that is being cleared.
    assign req_ready[i] = reset & ~full[i];

    // x0 writes complete the handshake but are never stored.
    assign push[i] = req_valid[i] & req_ready[i] & (req_rd[5*i +: 5] != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // Payload storage needs no reset: an entry is only ever read after it
    // has been written, because empty gates the arbiter.
    always_ff @(posedge clock) begin
      if (push[i]) begin
        mem_rd[wr_ptr[AW-1:0]]   <= req_rd[5*i +: 5];
        mem_data[wr_ptr[AW-1:0]] <= req_data[XLEN*i +: XLEN];
      end
    end

    assign head_rd_all[5*i +: 5]         = mem_rd[rd_ptr[AW-1:0]];
    assign head_data_all[XLEN*i +: XLEN] = mem_data[rd_ptr[AW-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search begins one past the last granted requester,
  // so every non-empty FIFO is served within NUM_REQ write cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot pop and head selection for the granted requester.
  always_comb begin
    pop      = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_valid && (grant_idx == GW'(k))) begin
        pop[k]   = 1'b1;
        sel_rd   = head_rd_all[5*k +: 5];
        sel_data = head_data_all[XLEN*k +: XLEN];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port and round-robin state. The asynchronous clear drops
  // an in-flight regWrite the moment reset asserts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regWrite   <= 1'b0;
      rd         <= '0;
      writeData  <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      regWrite <= grant_valid;
      if (grant_valid) begin
        rd         <= sel_rd;
        writeData  <= sel_data;
        last_grant <= grant_idx;
      end
    end
  end

  assign wb_idle = (&empty) & ~regWrite;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                    clock;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*5-1:0]    req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic                    regWrite;
  logic [4:0]              rd;
  logic [XLEN-1:0]         writeData;
  logic                    wb_idle;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_writeback_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .FIFO_DEPTH(2),
    .XLEN      (XLEN)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd   (req_rd),
    .req_data (req_data),
    .regWrite (regWrite),
    .rd       (rd),
    .writeData(writeData),
    .wb_idle  (wb_idle)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  typedef struct {
    int              req;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] data_in;
    bit              exp_write;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
  } vec_t;

  ent_t drv_q0[$];
  ent_t drv_q1[$];
  ent_t exp_q[$];
  ent_t got_q[$];
  int   got_cyc[$];
  int   acc1_cyc[$];

  bit   manual;
  bit   stall_en;
  bit   acc0;
  bit   acc1;
  int   cyc;
  int   total;
  int   bad;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      if (drv_q0.size() == 0 && drv_q1.size() == 0 && !acc0 && !acc1 && wb_idle)
        done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles waiting for idle", name, budget);
    end
    tick(2);
  endtask

  task automatic check_sb(input string name);
    int n;
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_rd%0d", name, i), 64'(got_q[i].rd), 64'(exp_q[i].rd));
      chk($sformatf("%s_data%0d", name, i), got_q[i].data, exp_q[i].data);
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver: presents queue heads at negedge, retires them once the handshake
  // at the following posedge has completed.
  // ---------------------------------------------------------------------------
  initial begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    forever begin
      @(negedge clock);
      if (!manual) begin
        if (acc0) void'(drv_q0.pop_front());
        if (acc1) void'(drv_q1.pop_front());
        if (drv_q0.size() > 0 && !(stall_en && $urandom_range(0, 2) == 0)) begin
          req_valid[0]       = 1'b1;
          req_rd[4:0]        = drv_q0[0].rd;
          req_data[XLEN-1:0] = drv_q0[0].data;
        end else begin
          req_valid[0] = 1'b0;
        end
        if (drv_q1.size() > 0 && !(stall_en && $urandom_range(0, 2) == 0)) begin
          req_valid[1]            = 1'b1;
          req_rd[9:5]             = drv_q1[0].rd;
          req_data[2*XLEN-1:XLEN] = drv_q1[0].data;
        end else begin
          req_valid[1] = 1'b0;
        end
        acc0 = req_valid[0] && req_ready[0];
        acc1 = req_valid[1] && req_ready[1];
        if (acc1) acc1_cyc.push_back(cyc);
      end else begin
        acc0 = 1'b0;
        acc1 = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: captures every register-file write.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clock);
      if (regWrite === 1'b1) begin
        got_q.push_back({rd, writeData});
        got_cyc.push_back(cyc);
        chk("write_rd_nonzero", 64'(rd != 5'd0), 64'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[6];

  initial begin
    total     = 0;
    bad       = 0;
    manual    = 1'b1;
    stall_en  = 1'b0;
    reset     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;

    vecs[0] = '{0, 5'd0,  64'hFFFF,                 1'b0, 5'd0,  64'h0};
    vecs[1] = '{0, 5'd7,  64'h1234,                 1'b1, 5'd7,  64'h1234};
    vecs[2] = '{1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{1, 5'd0,  64'h55,                   1'b0, 5'd0,  64'h0};
    vecs[4] = '{1, 5'd1,  64'h0,                    1'b1, 5'd1,  64'h0};
    vecs[5] = '{0, 5'd16, 64'h8000_0000_0000_0001,  1'b1, 5'd16, 64'h8000_0000_0000_0001};

    // Reset state
    tick(2);
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_writeData", writeData, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_idle", 64'(wb_idle), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("rel_ready", 64'(req_ready), 64'd3);
    chk("rel_idle", 64'(wb_idle), 64'd1);

    // Single write: accepted at edge k, visible only after edge k+1
    req_valid[0]       = 1'b1;
    req_rd[4:0]        = 5'd5;
    req_data[XLEN-1:0] = 64'hDEAD;
    @(posedge clock);
    #1;
    chk("single_k_regWrite", 64'(regWrite), 64'd0);
    chk("single_k_idle", 64'(wb_idle), 64'd0);
    @(negedge clock);
    req_valid[0] = 1'b0;
    @(posedge clock);
    #1;
    chk("single_k1_regWrite", 64'(regWrite), 64'd1);
    chk("single_k1_rd", 64'(rd), 64'd5);
    chk("single_k1_data", writeData, 64'hDEAD);
    chk("single_k1_idle", 64'(wb_idle), 64'd0);
    @(posedge clock);
    #1;
    chk("single_k2_regWrite", 64'(regWrite), 64'd0);
    chk("single_k2_rd_hold", 64'(rd), 64'd5);
    chk("single_k2_idle", 64'(wb_idle), 64'd1);
    tick(1);
    got_q.delete();
    got_cyc.delete();

    // Table-driven single-request vectors
    for (int v = 0; v < 6; v++) begin
      req_valid[vecs[v].req]            = 1'b1;
      req_rd[5*vecs[v].req +: 5]        = vecs[v].rd_in;
      req_data[XLEN*vecs[v].req +: XLEN] = vecs[v].data_in;
      @(negedge clock);
      req_valid = '0;
      tick(3);
      chk($sformatf("vec%0d_nwrites", v), 64'(got_q.size()), 64'(vecs[v].exp_write));
      if (got_q.size() > 0) begin
        chk($sformatf("vec%0d_rd", v), 64'(got_q[0].rd), 64'(vecs[v].exp_rd));
        chk($sformatf("vec%0d_data", v), got_q[0].data, vecs[v].exp_data);
      end
      chk($sformatf("vec%0d_idle", v), 64'(wb_idle), 64'd1);
      got_q.delete();
      got_cyc.delete();
    end

    // x0 drop back-to-back on requester 0
    manual = 1'b0;
    drv_q0.push_back({5'd0, 64'hFFFF});
    drv_q0.push_back({5'd7, 64'hABCD});
    exp_q.push_back({5'd7, 64'hABCD});
    wait_idle("x0drop", 50);
    check_sb("x0drop");

    // Reset mid-stream with entries queued
    manual = 1'b1;
    tick(1);
    req_valid                = 2'b11;
    req_rd                   = {5'd3, 5'd2};
    req_data                 = {64'h33, 64'h22};
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("midrst_pre_regWrite", 64'(regWrite), 64'd1);
    @(negedge clock);
    req_valid = '0;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_regWrite", 64'(regWrite), 64'd0);
    chk("midrst_rd", 64'(rd), 64'd0);
    chk("midrst_writeData", writeData, 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_idle", 64'(wb_idle), 64'd1);
    tick(1);
    reset = 1'b1;
    #1;
    chk("midrst_rel_ready", 64'(req_ready), 64'd3);
    got_q.delete();
    got_cyc.delete();
    tick(5);
    chk("midrst_no_writes", 64'(got_q.size()), 64'd0);
    chk("midrst_idle_after", 64'(wb_idle), 64'd1);

    // Contention: strict alternation, six back-to-back writes
    manual = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drv_q0.push_back({5'(i), 64'(100 + i)});
      drv_q1.push_back({5'(10 + i), 64'(200 + i)});
    end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({5'(i), 64'(100 + i)});
      exp_q.push_back({5'(10 + i), 64'(200 + i)});
    end
    wait_idle("contend", 60);
    if (got_cyc.size() >= 6) begin
      for (int i = 1; i < 6; i++)
        chk($sformatf("contend_gap%0d", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'd1);
    end
    check_sb("contend");

    // Full / backpressure on requester 1 while requester 0 stays busy
    acc1_cyc.delete();
    for (int i = 0; i < 4; i++) drv_q0.push_back({5'(20 + i), 64'hA0 + 64'(i)});
    for (int i = 0; i < 3; i++) drv_q1.push_back({5'(24 + i), 64'hB0 + 64'(i)});
    exp_q.push_back({5'd20, 64'hA0});
    exp_q.push_back({5'd24, 64'hB0});
    exp_q.push_back({5'd21, 64'hA1});
    exp_q.push_back({5'd25, 64'hB1});
    exp_q.push_back({5'd22, 64'hA2});
    exp_q.push_back({5'd26, 64'hB2});
    exp_q.push_back({5'd23, 64'hA3});
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick(1);
        if (drv_q1.size() <= 1) seen = 1'b1;
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL full_two_pushes: timeout waiting for two req1 pushes");
      end
    end
    chk("full_ready1_low", 64'(req_ready[1]), 64'd0);
    wait_idle("full", 60);
    chk("full_acc_count", 64'(acc1_cyc.size()), 64'd3);
    if (acc1_cyc.size() >= 3) begin
      chk("full_acc_gap1", 64'(acc1_cyc[1] - acc1_cyc[0]), 64'd1);
      chk("full_acc_gap2", 64'(acc1_cyc[2] - acc1_cyc[1]), 64'd2);
    end
    check_sb("full");

    // Pointer wrap with random input stalls
    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ent_t e;
      e.rd   = 5'($urandom_range(1, 31));
      e.data = {$urandom, $urandom};
      drv_q0.push_back(e);
      exp_q.push_back(e);
    end
    wait_idle("wrap", 400);
    stall_en = 1'b0;
    check_sb("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
